// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter: two one-entry holding slots (ALU path, load path) share the
// register file's single write port. Occupied slots are granted round-robin and the
// winner is driven onto registered write-port outputs. Writes to r0 are dropped at
// acceptance, and a saturating counter records cycles where both slots were occupied.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_id,
  output logic [CNT_W-1:0]  contention_cnt
);

  // Holding slots
  logic              full0_q, full0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic              full1_q, full1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] data1_q, data1_d;

  // Arbitration and output state
  logic              last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic grant0, grant1;
  logic accept0, accept1;
  logic keep0, keep1;
  logic contended;

  assign contended = full0_q && full1_q;

  // Grant decision from slot occupancy only; on contention the last loser wins.
  always_comb begin
    grant0 = full0_q;
    grant1 = full1_q;
    if (contended) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end
  end

  // A slot being drained this cycle can be refilled on the same edge.
  assign req0_ready = !full0_q || grant0;
  assign req1_ready = !full1_q || grant1;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  // r0 writes complete the handshake but never occupy the slot.
  assign keep0   = accept0 && (req0_addr != '0);
  assign keep1   = accept1 && (req1_addr != '0);

  // Slot next-state: clear on grant, refill (higher priority) on a kept transfer.
  always_comb begin
    full0_d = full0_q;
    addr0_d = addr0_q;
    data0_d = data0_q;
    full1_d = full1_q;
    addr1_d = addr1_q;
    data1_d = data1_q;
    if (grant0) full0_d = 1'b0;
    if (grant1) full1_d = 1'b0;
    if (keep0) begin
      full0_d = 1'b1;
      addr0_d = req0_addr;
      data0_d = req0_data;
    end
    if (keep1) begin
      full1_d = 1'b1;
      addr1_d = req1_addr;
      data1_d = req1_data;
    end
  end

  // Output port, round-robin pointer and contention counter next-state.
  always_comb begin
    reg_write_d  = grant0 || grant1;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (grant0) begin
      write_reg_d  = addr0_q;
      write_data_d = data0_q;
      grant_id_d   = 1'b0;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      write_reg_d  = addr1_q;
      write_data_d = data1_q;
      grant_id_d   = 1'b1;
      last_grant_d = 1'b1;
    end
    if (contended && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset discards pending slot contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0_q      <= 1'b0;
      addr0_q      <= '0;
      data0_q      <= '0;
      full1_q      <= 1'b0;
      addr1_q      <= '0;
      data1_q      <= '0;
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      full0_q      <= full0_d;
      addr0_q      <= addr0_d;
      data0_q      <= data0_d;
      full1_q      <= full1_d;
      addr1_q      <= addr1_d;
      data1_q      <= data1_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;
  assign grant_id       = grant_id_q;
  assign contention_cnt = cnt_q;

endmodule
